// File: rtl/simon_pkg.sv
// Shared SIMON32/64 definitions used by the encryption and decryption
// controllers: controller state encoding, round/key constants, the z0
// sequence and the word rotate helpers.
package simon_pkg;

  localparam int N_ROUNDS    = 32;
  localparam int N_KEY_WORDS = 4;

  // ~k ^ 3 folded into a single xor constant.
  localparam logic [15:0] KEY_CONST = 16'hFFFC;

  // z0 with bit 0 being the leftmost character; read it through z0_bit().
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_READ,
    ST_LOAD,
    ST_ROUND,
    ST_WRITE,
    ST_DONE
  } simon_state_e;

  function automatic logic [15:0] ror1(input logic [15:0] v);
    return {v[0], v[15:1]};
  endfunction

  function automatic logic [15:0] ror3(input logic [15:0] v);
    return {v[2:0], v[15:3]};
  endfunction

  // Only indices 0..27 are needed for 32 rounds with 4 key words.
  function automatic logic z0_bit(input logic [4:0] j);
    return Z0[6'd61 - {1'b0, j}];
  endfunction

endpackage

// File: rtl/simon32_64_key_schedule.sv
// SIMON32/64 round-key register file with the expansion step.
//   clk       : clock
//   load      : capture key words k0..k3 into rk[0..3]
//   key       : 64-bit key, k0 = [15:0]
//   step_en   : compute rk[step_idx] from rk[step_idx-1/-3/-4]
//   step_idx  : expansion index, 4..31
//   rd_idx    : read port index
//   rd_key    : rk[rd_idx]
// Contents are not reset; they are always rewritten before use.
module simon32_64_key_schedule
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic [63:0] key,
  input  logic        step_en,
  input  logic [4:0]  step_idx,
  input  logic [4:0]  rd_idx,
  output logic [15:0] rd_key
);

  logic [15:0] rk [N_ROUNDS];
  logic [15:0] tmp;
  logic [15:0] next_key;

  always_comb begin
    tmp      = ror3(rk[step_idx - 5'd1]) ^ rk[step_idx - 5'd3];
    next_key = KEY_CONST
             ^ {15'b0, z0_bit(step_idx - 5'd4)}
             ^ rk[step_idx - 5'd4]
             ^ tmp
             ^ ror1(tmp);
  end

  always_ff @(posedge clk) begin
    if (load) begin
      rk[0] <= key[15:0];
      rk[1] <= key[31:16];
      rk[2] <= key[47:32];
      rk[3] <= key[63:48];
    end else if (step_en) begin
      rk[step_idx] <= next_key;
    end
  end

  assign rd_key = rk[rd_idx];

endmodule

// File: rtl/simon_iterative_decipher_core_ctrl.sv
// SIMON32/64 decryption controller. Expands the key, then per block reads
// ciphertext from the ciphertext BRAM, steps an external inverse-round core
// through 32 rounds (rk[31] first) and writes plaintext to the plaintext
// BRAM. Pulses done_intr once all blocks are written.
//   clk, rst            : clock, synchronous active-high reset
//   ctrl_in_*           : start request, block count and key (latched on start)
//   done_intr           : one-cycle completion pulse
//   ct_*                : ciphertext BRAM port (read only, 1-cycle latency)
//   pt_*                : plaintext BRAM port (write only)
//   core_*              : external inverse-round core handshake
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | wait for ctrl_in_begin; latch key and block count
// ST_EXPAND | compute rk[4..31], one per cycle (cnt = key index)
// ST_READ   | present ciphertext address of current block
// ST_LOAD   | ciphertext valid; core captures it
// ST_ROUND  | one inverse round per cycle, cnt counts 31 down to 0
// ST_WRITE  | write core result, advance block
// ST_DONE   | done_intr pulse
module simon_iterative_decipher_core_ctrl
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_in_begin,
  input  logic [10:0] ctrl_in_num_blocks,
  input  logic [63:0] ctrl_in_key,
  output logic        done_intr,
  output logic        ct_clka,
  output logic        ct_rsta,
  output logic        ct_ena,
  output logic [3:0]  ct_wea,
  output logic [31:0] ct_addra,
  output logic [31:0] ct_wr_data,
  input  logic [31:0] ct_rd_data,
  output logic        pt_clka,
  output logic        pt_rsta,
  output logic        pt_ena,
  output logic [31:0] pt_addra,
  output logic [31:0] pt_wr_data,
  output logic [3:0]  pt_wea,
  input  logic [31:0] pt_rd_data,
  output logic        core_load,
  output logic [31:0] core_ciphertext,
  output logic        core_round_en,
  output logic [15:0] core_round_key,
  input  logic [31:0] core_plaintext
);

  localparam logic [4:0] FIRST_EXP_IDX = 5'(N_KEY_WORDS);
  localparam logic [4:0] LAST_KEY_IDX  = 5'(N_ROUNDS - 1);

  simon_state_e state, state_d;
  logic [4:0]   cnt, cnt_d;
  logic [10:0]  block, block_d;
  logic [10:0]  num_blocks_q, num_blocks_d;
  logic [10:0]  block_inc;
  logic [31:0]  addr;

  logic         ks_load;
  logic         ks_step;
  logic [15:0]  ks_rd_key;

  logic         unused_pt_rd;

  simon32_64_key_schedule u_key_schedule (
    .clk      (clk),
    .load     (ks_load),
    .key      (ctrl_in_key),
    .step_en  (ks_step),
    .step_idx (cnt),
    .rd_idx   (cnt),
    .rd_key   (ks_rd_key)
  );

  // Max block index 2046 -> 0x1FF8, so the byte address never wraps.
  assign addr      = {19'b0, block, 2'b00};
  assign block_inc = block + 11'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      block        <= '0;
      num_blocks_q <= '0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      block        <= block_d;
      num_blocks_q <= num_blocks_d;
    end
  end

  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    block_d        = block;
    num_blocks_d   = num_blocks_q;
    ks_load        = 1'b0;
    ks_step        = 1'b0;
    core_load      = 1'b0;
    core_round_en  = 1'b0;
    core_round_key = '0;
    pt_wea         = 4'h0;
    pt_wr_data     = '0;
    done_intr      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (ctrl_in_begin) begin
          ks_load      = 1'b1;
          num_blocks_d = ctrl_in_num_blocks;
          block_d      = '0;
          cnt_d        = FIRST_EXP_IDX;
          state_d      = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        ks_step = 1'b1;
        if (cnt == LAST_KEY_IDX) begin
          cnt_d   = '0;
          state_d = (num_blocks_q == 11'd0) ? ST_DONE : ST_READ;
        end else begin
          cnt_d = cnt + 5'd1;
        end
      end
      ST_READ: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        core_load = 1'b1;
        cnt_d     = LAST_KEY_IDX;
        state_d   = ST_ROUND;
      end
      ST_ROUND: begin
        // cnt is both the remaining-round down-counter and the key index,
        // which gives rk[31] first and rk[0] on the terminal count.
        core_round_en  = 1'b1;
        core_round_key = ks_rd_key;
        if (cnt == 5'd0) begin
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt - 5'd1;
        end
      end
      ST_WRITE: begin
        pt_wea     = 4'hF;
        pt_wr_data = core_plaintext;
        block_d    = block_inc;
        state_d    = (block_inc < num_blocks_q) ? ST_READ : ST_DONE;
      end
      ST_DONE: begin
        done_intr = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ct_clka         = clk;
  assign ct_rsta         = rst;
  assign ct_ena          = 1'b1;
  assign ct_wea          = 4'h0;
  assign ct_addra        = addr;
  assign ct_wr_data      = '0;
  assign pt_clka         = clk;
  assign pt_rsta         = rst;
  assign pt_ena          = 1'b1;
  assign pt_addra        = addr;
  assign core_ciphertext = ct_rd_data;

  assign unused_pt_rd = ^pt_rd_data;

endmodule
